// File: rtl/next_pc_gen.sv
// next_pc_gen: next-PC selection for the fetch stage.
// Drives the PC register's add_in (pc_next) from the registered pc_cur,
// handling sequential fetch, imem wait states, pipeline stall, taken
// branches/jumps with an optional architectural delay slot, and exception
// vectoring with EPC / branch-delay capture.
//
// Optional build macro: BRANCH_STATS_EN
//   defined   -> redirect_cnt counts accepted redirects, saturating at all-ones
//   undefined -> no counter is built, redirect_cnt is tied to zero
//
// state | meaning
// ------+-------------------------------------------------------------------
// BOOT  | first cycle out of reset, pc_next = RESET_VECTOR, no fetch request
// RUN   | normal sequential fetch, redirects accepted here
// DELAY | delay-slot instruction fetching, tgt_q issued on the next advance

module next_pc_gen #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
    parameter bit          DELAY_SLOT   = 1'b1
) (
    input  logic        clk,
    input  logic        clk_reset,
    input  logic [31:0] pc_cur,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        j_valid,
    input  logic [31:0] j_target,
    input  logic        exc_req,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] epc,
    output logic        exc_bd,
    output logic        misalign_err,
    output logic [31:0] redirect_cnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DELAY = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] epc_q, epc_d;
    logic        exc_bd_q, exc_bd_d;
    logic        misalign_q, misalign_d;
    logic        redirect_acc;

    logic        advance;
    logic        redirect;
    logic [31:0] sel_raw;
    logic [31:0] sel_tgt;
    logic [31:0] pc_plus4;
    logic [31:0] pc_minus4;

    assign advance   = !stall && imem_ack;
    assign redirect  = br_taken || j_valid;
    assign sel_raw   = br_taken ? br_target : j_target;
    assign sel_tgt   = {sel_raw[31:2], 2'b00};
    assign pc_plus4  = pc_cur + 32'd4;
    assign pc_minus4 = pc_cur - 32'd4;

    // Next-PC, fetch request and next register values from state and inputs.
    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        epc_d        = epc_q;
        exc_bd_d     = exc_bd_q;
        misalign_d   = 1'b0;
        redirect_acc = 1'b0;
        pc_next      = pc_plus4;
        imem_req     = 1'b1;

        case (state_q)
            RUN, DELAY: begin
                if (exc_req) begin
                    pc_next = EXC_VECTOR;
                    if (state_q == DELAY) begin
                        epc_d    = pc_minus4;
                        exc_bd_d = 1'b1;
                    end else begin
                        epc_d    = pc_cur;
                        exc_bd_d = 1'b0;
                    end
                    state_d = RUN;
                    tgt_d   = 32'h0;
                end else if (!advance) begin
                    pc_next = pc_cur;
                end else if (state_q == DELAY) begin
                    // Branch in a delay slot is unsupported: redirects ignored.
                    pc_next = tgt_q;
                    state_d = RUN;
                end else if (redirect) begin
                    redirect_acc = 1'b1;
                    misalign_d   = (sel_raw[1:0] != 2'b00);
                    if (DELAY_SLOT) begin
                        pc_next = pc_plus4;
                        tgt_d   = sel_tgt;
                        state_d = DELAY;
                    end else begin
                        pc_next = sel_tgt;
                    end
                end
            end
            default: begin
                // BOOT, and any illegal encoding, restarts cleanly.
                pc_next  = RESET_VECTOR;
                imem_req = 1'b0;
                state_d  = RUN;
            end
        endcase
    end

    // State and captured exception/target registers.
    always_ff @(posedge clk or posedge clk_reset) begin
        if (clk_reset) begin
            state_q    <= BOOT;
            tgt_q      <= 32'h0;
            epc_q      <= 32'h0;
            exc_bd_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            epc_q      <= epc_d;
            exc_bd_q   <= exc_bd_d;
            misalign_q <= misalign_d;
        end
    end

    assign epc          = epc_q;
    assign exc_bd       = exc_bd_q;
    assign misalign_err = misalign_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] cnt_q, cnt_d;

    // Saturating count of accepted redirects.
    always_comb begin
        cnt_d = cnt_q;
        if (redirect_acc && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Redirect counter register.
    always_ff @(posedge clk or posedge clk_reset) begin
        if (clk_reset) begin
            cnt_q <= 32'h0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign redirect_cnt = cnt_q;
`else
    logic unused_redirect_acc;
    assign unused_redirect_acc = redirect_acc;
    assign redirect_cnt        = 32'h0;
`endif

endmodule

// File: tb/tb_next_pc_gen.sv
// Bench for next_pc_gen: directed vectors with hand-computed pc_next values,
// plus a behavioural model compared against every output on every cycle.
module tb_next_pc_gen;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] EV = 32'h8000_0180;
    localparam bit          DS = 1'b1;

    logic        clk = 1'b0;
    logic        clk_reset = 1'b1;
    logic [31:0] pc_cur = 32'h0;
    logic        imem_ack = 1'b0;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        j_valid = 1'b0;
    logic [31:0] j_target = 32'h0;
    logic        exc_req = 1'b0;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] epc;
    logic        exc_bd;
    logic        misalign_err;
    logic [31:0] redirect_cnt;

    int n_vec = 0;
    int n_err = 0;

    next_pc_gen #(.RESET_VECTOR(RV), .EXC_VECTOR(EV), .DELAY_SLOT(DS)) dut (
        .clk(clk), .clk_reset(clk_reset), .pc_cur(pc_cur), .imem_ack(imem_ack),
        .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .j_valid(j_valid), .j_target(j_target), .exc_req(exc_req),
        .pc_next(pc_next), .imem_req(imem_req), .epc(epc), .exc_bd(exc_bd),
        .misalign_err(misalign_err), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Architectural view: "booting", "a redirect is owed after one more
    // instruction" and the owed address, plus the captured exception info.
    bit          m_boot = 1'b1;
    bit          m_owed = 1'b0;
    logic [31:0] m_owed_pc = 32'h0;
    logic [31:0] m_epc = 32'h0;
    bit          m_bd = 1'b0;
    bit          m_mis = 1'b0;
    logic [31:0] m_cnt = 32'h0;

    // Compare process: mid-cycle, inputs stable, before the next rising edge.
    always begin
        logic [31:0] e_pc;
        logic        e_req;
        logic [31:0] t;
        bit          nx_mis;
        @(negedge clk);
        #4;
        if (clk_reset) begin
            m_boot = 1'b1; m_owed = 1'b0; m_owed_pc = 32'h0;
            m_epc = 32'h0; m_bd = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
        end
        nx_mis = 1'b0;
        e_req  = !m_boot;
        if (m_boot) begin
            e_pc = RV;
        end else if (exc_req) begin
            e_pc = EV;
        end else if (stall || !imem_ack) begin
            e_pc = pc_cur;
        end else if (m_owed) begin
            e_pc = m_owed_pc;
        end else if (br_taken || j_valid) begin
            t = br_taken ? br_target : j_target;
            nx_mis = (t % 4) != 0;
            t = t - (t % 4);
            e_pc = DS ? pc_cur + 32'd4 : t;
        end else begin
            e_pc = pc_cur + 32'd4;
        end
`ifdef BRANCH_STATS_EN
        chk("redirect_cnt", redirect_cnt, m_cnt);
`else
        chk("redirect_cnt", redirect_cnt, 32'h0);
`endif
        chk("pc_next", pc_next, e_pc);
        chk("imem_req", {31'h0, imem_req}, {31'h0, e_req});
        chk("epc", epc, m_epc);
        chk("exc_bd", {31'h0, exc_bd}, {31'h0, m_bd});
        chk("misalign_err", {31'h0, misalign_err}, {31'h0, m_mis});
        // Advance the model to what holds after the coming rising edge.
        if (!clk_reset) begin
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (exc_req) begin
                m_bd   = m_owed;
                m_epc  = m_owed ? pc_cur - 32'd4 : pc_cur;
                m_owed = 1'b0;
            end else if (stall || !imem_ack) begin
                // hold
            end else if (m_owed) begin
                m_owed = 1'b0;
            end else if (br_taken || j_valid) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (DS) begin
                    m_owed    = 1'b1;
                    m_owed_pc = t;
                end
            end
            m_mis = nx_mis;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic vec(input logic [31:0] pc, input logic ack, input logic st,
                       input logic br, input logic [31:0] bt,
                       input logic jv, input logic [31:0] jt,
                       input logic ex, input logic [31:0] exp_pc);
        @(negedge clk);
        clk_reset = 1'b0;
        pc_cur = pc; imem_ack = ack; stall = st;
        br_taken = br; br_target = bt; j_valid = jv; j_target = jt; exc_req = ex;
        #4;
        chk("hand_pc_next", pc_next, exp_pc);
    endtask

    task automatic seq(input logic [31:0] pc, input logic [31:0] exp_pc);
        vec(pc, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, exp_pc);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        // BOOT cycle ignores inputs, including an exception request
        vec(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        chk("hand_boot_req", {31'h0, imem_req}, 32'h0);
        seq(32'h0, 32'h4);
        chk("hand_run_req", {31'h0, imem_req}, 32'h1);
        chk("hand_epc_boot", epc, 32'h0);

        // imem wait states then stall, then release
        for (int i = 0; i < 3; i++)
            vec(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h40);
        for (int i = 0; i < 2; i++)
            vec(32'h40, 1'b1, 1'b1, 1'b1, 32'h900, 1'b0, 32'h0, 1'b0, 32'h40);
        seq(32'h40, 32'h44);

        // taken branch with delay slot; jump during DELAY is ignored
        vec(32'h100, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h104);
        vec(32'h104, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h600, 1'b0, 32'h200);
`ifdef BRANCH_STATS_EN
        chk("hand_cnt", redirect_cnt, 32'h1);
`else
        chk("hand_cnt", redirect_cnt, 32'h0);
`endif
        seq(32'h200, 32'h204);

        // exception in the delay slot
        vec(32'h100, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h104);
        vec(32'h104, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8000_0180);
        seq(32'h8000_0180, 32'h8000_0184);
        chk("hand_epc_bd", epc, 32'h100);
        chk("hand_bd", {31'h0, exc_bd}, 32'h1);

        // simultaneous branch and jump, misaligned branch target
        vec(32'h10, 1'b1, 1'b0, 1'b1, 32'h302, 1'b1, 32'h500, 1'b0, 32'h14);
        seq(32'h14, 32'h300);
        chk("hand_misalign_pulse", {31'h0, misalign_err}, 32'h1);
        seq(32'h300, 32'h304);
        chk("hand_misalign_clear", {31'h0, misalign_err}, 32'h0);

        // jump alone, exception in RUN beats the redirect
        vec(32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h700, 1'b1, 32'h8000_0180);
        seq(32'h8000_0180, 32'h8000_0184);
        chk("hand_epc_run", epc, 32'h20);
        chk("hand_bd_run", {31'h0, exc_bd}, 32'h0);

        // stall while in DELAY holds, then target issues
        vec(32'h30, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h800, 1'b0, 32'h34);
        vec(32'h34, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h34);
        seq(32'h34, 32'h800);

        // wrap at the top of the address space
        seq(32'hFFFF_FFFC, 32'h0);

        // reset asserted mid-DELAY: async return to RESET_VECTOR, target lost
        vec(32'h50, 1'b1, 1'b0, 1'b1, 32'h70, 1'b0, 32'h0, 1'b0, 32'h54);
        @(negedge clk);
        pc_cur = 32'h54; br_taken = 1'b0;
        #1;
        clk_reset = 1'b1;
        #1;
        chk("hand_async_pc", pc_next, RV);
        chk("hand_async_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        seq(32'h54, 32'h0);
        seq(32'h0, 32'h4);
        seq(32'h4, 32'h8);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/next_pc_gen.md
Name: next_pc_gen

Overview:
- Drives the next-PC value into the PC register's add_in port, and reads back the registered PC as pc_cur.
- Handles sequential fetch, instruction-memory wait states, pipeline stall, taken branches and jumps with an architectural delay slot, and exception vectoring with EPC/BD capture.
- Guarantees pc_next is never X or undefined from the first cycle after reset.

Parameters:
RESET_VECTOR, 32'h0000_0000, pc_next value during BOOT
EXC_VECTOR, 32'h8000_0180, exception handler address
DELAY_SLOT, 1, 1 = MIPS delay slot honoured; 0 = redirect takes effect immediately

Ports:
clk  in  1  system clock, rising edge
clk_reset  in  1  asynchronous, active-high reset
pc_cur  in  32  current PC from PC register
imem_ack  in  1  instruction memory returned word at pc_cur this cycle
stall  in  1  pipeline hold request from hazard unit
br_taken  in  1  branch resolved taken (qualifies br_target)
br_target  in  32  branch target
j_valid  in  1  jump/jr issued (qualifies j_target)
j_target  in  32  jump target
exc_req  in  1  single-cycle exception request
pc_next  out  32  next PC to PC register
imem_req  out  1  fetch request at pc_cur
epc  out  32  captured exception PC
exc_bd  out  1  exception occurred in delay slot
misalign_err  out  1  one-cycle pulse, redirect target bits[1:0] != 0
redirect_cnt  out  32  taken-redirect count (optional feature)

Behaviour:
- States: BOOT, RUN, DELAY. Registers: state, tgt_q[31:0], epc, exc_bd, misalign_err, plus redirect_cnt when BRANCH_STATS_EN is defined.
- Reset (async, high): state=BOOT, tgt_q=0, epc=0, exc_bd=0, misalign_err=0, redirect_cnt=0.
- All pc_next and imem_req logic is combinational from the registers and inputs. pc_next is never X.
- BOOT:
  - pc_next=RESET_VECTOR, imem_req=0.
  - Next cycle goes to RUN unconditionally; inputs are ignored.
- In RUN and DELAY, imem_req=1.
- advance = !stall && imem_ack.
- Redirect selection: br_taken has priority over j_valid. tgt = selected target with bits[1:0] forced to 0. misalign_err is registered and pulses the cycle after any selected target has bits[1:0] != 0.
- Priority, highest first:
  1. exc_req (any state except BOOT):
     - pc_next=EXC_VECTOR.
     - If state is DELAY: epc<=pc_cur-4 and exc_bd<=1. Otherwise: epc<=pc_cur and exc_bd<=0.
     - state<=RUN, and any pending target is discarded.
     - Overrides stall, imem_ack and redirects.
  2. !advance: pc_next=pc_cur; state and tgt_q hold; redirect inputs are ignored.
  3. RUN with a redirect:
     - DELAY_SLOT=1: pc_next=pc_cur+4, tgt_q<=tgt, state<=DELAY.
     - DELAY_SLOT=0: pc_next=tgt, state stays RUN.
  4. DELAY: pc_next=tgt_q, state<=RUN. A redirect arriving in DELAY is ignored (branch-in-delay-slot is not supported).
  5. RUN, otherwise: pc_next=pc_cur+4.
- Arithmetic: pc_cur+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Redirect counting: counts a redirect only when it is accepted (case 3).
- Reset mid-DELAY: pending target is lost; restart from BOOT.

Optional Feature:
BRANCH_STATS_EN
- Defined: redirect_cnt increments by 1 on each accepted redirect. It saturates at 32'hFFFF_FFFF and is cleared by reset.
- Undefined: the counter is not built and redirect_cnt is tied to 32'h0.

Test Plan:
- Reset then release, pc_cur=0, imem_ack=1 → BOOT cycle gives pc_next=0 and imem_req=0; next cycle pc_next=4 and imem_req=1.
- pc_cur=0x40, imem_ack=0 for 3 cycles, then stall=1 for 2 cycles → pc_next=0x40 throughout; after release pc_next=0x44.
- DELAY_SLOT=1, pc_cur=0x100, br_taken=1, br_target=0x200 → pc_next=0x104; next advance (pc_cur=0x104) gives pc_next=0x200. A j_valid asserted during DELAY is ignored. With BRANCH_STATS_EN defined, redirect_cnt=1.
- In DELAY with pc_cur=0x104, exc_req=1 → pc_next=0x8000_0180, epc=0x100, exc_bd=1, state RUN, tgt_q discarded.
- br_taken and j_valid together, br_target=0x302, j_target=0x500 → 0x300 is used and misalign_err pulses one cycle.
- pc_cur=0xFFFF_FFFC, advance → pc_next=0x0. Asserting clk_reset mid-stream forces BOOT and pc_next=RESET_VECTOR asynchronously.
